// File: rtl/shared_port_if.sv
// Bundle of grant, device-data and shared-port signals around shared_port.
// Latency: none; wires only.
// Backpressure: none; grants come from the upstream arbiter. Build macro: SHARED_PORT_STATS_EN adds cnt1/cnt2.
interface shared_port_if #(
  parameter int W  = 8
`ifdef SHARED_PORT_STATS_EN
  , parameter int CW = 8
`endif
);
  logic         g1;
  logic         g2;
  logic         v1;
  logic         v2;
  logic [W-1:0] d1;
  logic [W-1:0] d2;
  logic [W-1:0] q;
  logic         qv;
  logic [1:0]   src;
  logic         ovf;
  logic         err;
`ifdef SHARED_PORT_STATS_EN
  logic [CW-1:0] cnt1;
  logic [CW-1:0] cnt2;

  modport master (output g1, g2, v1, v2, d1, d2,
                  input  q, qv, src, ovf, err, cnt1, cnt2);
  modport slave  (input  g1, g2, v1, v2, d1, d2,
                  output q, qv, src, ovf, err, cnt1, cnt2);
`else
  modport master (output g1, g2, v1, v2, d1, d2,
                  input  q, qv, src, ovf, err);
  modport slave  (input  g1, g2, v1, v2, d1, d2,
                  output q, qv, src, ovf, err);
`endif
endinterface

// File: rtl/shared_port.sv
// Forwards the granted device's word to one registered shared port, tags its source, polices grants.
// Latency: one cycle from sampled grant/valid to q/qv/src/ovf/err; no combinational input-to-output path.
// Backpressure: none; grants are obeyed as sampled. Build macro: SHARED_PORT_STATS_EN adds per-device word counters.
module shared_port #(
  parameter int W    = 8,
  parameter int MAXB = 4
`ifdef SHARED_PORT_STATS_EN
  , parameter int CW = 8
`endif
) (
  input  logic         ck,
  input  logic         reset,
  shared_port_if.slave bus
);

  // Burst counter must hold MAXB+1, where it saturates.
  localparam int BCW = $clog2(MAXB + 2);
  localparam logic [BCW-1:0] BC_MAX = BCW'(MAXB + 1);
  localparam logic [BCW-1:0] BC_LIM = BCW'(MAXB);
  localparam logic [BCW-1:0] BC_ONE = BCW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE1 = 2'd1,
    SERVE2 = 2'd2,
    ERR    = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [BCW-1:0] bc_q,    bc_d;
  logic [W-1:0]   q_q,     q_d;
  logic           qv_q,    qv_d;
  logic [1:0]     src_q,   src_d;
  logic           ovf_q,   ovf_d;
  logic           err_q,   err_d;
`ifdef SHARED_PORT_STATS_EN
  logic [CW-1:0]  cnt1_q,  cnt1_d;
  logic [CW-1:0]  cnt2_q,  cnt2_d;
`endif

  // Next-state, burst count and shared-port output computation.
  always_comb begin
    state_d = state_q;
    bc_d    = bc_q;
    q_d     = q_q;
    qv_d    = 1'b0;
    src_d   = src_q;
    ovf_d   = 1'b0;
    err_d   = err_q;
`ifdef SHARED_PORT_STATS_EN
    cnt1_d  = cnt1_q;
    cnt2_d  = cnt2_q;
`endif

    if (state_q == ERR) begin
      // Terminal until reset: port silent, counters frozen.
      state_d = ERR;
      src_d   = 2'd0;
      err_d   = 1'b1;
    end else if (bus.g1 && bus.g2) begin
      state_d = ERR;
      bc_d    = '0;
      src_d   = 2'd0;
      err_d   = 1'b1;
    end else if (bus.g1) begin
      state_d = SERVE1;
      src_d   = 2'd1;
      if (state_q != SERVE1) begin
        bc_d = BC_ONE;
      end else if (bc_q == BC_MAX) begin
        bc_d = BC_MAX;
      end else begin
        bc_d = bc_q + BC_ONE;
      end
      ovf_d = (bc_d > BC_LIM);
      if (bus.v1) begin
        q_d  = bus.d1;
        qv_d = 1'b1;
`ifdef SHARED_PORT_STATS_EN
        cnt1_d = cnt1_q + CW'(1);
`endif
      end
    end else if (bus.g2) begin
      state_d = SERVE2;
      src_d   = 2'd2;
      if (state_q != SERVE2) begin
        bc_d = BC_ONE;
      end else if (bc_q == BC_MAX) begin
        bc_d = BC_MAX;
      end else begin
        bc_d = bc_q + BC_ONE;
      end
      ovf_d = (bc_d > BC_LIM);
      if (bus.v2) begin
        q_d  = bus.d2;
        qv_d = 1'b1;
`ifdef SHARED_PORT_STATS_EN
        cnt2_d = cnt2_q + CW'(1);
`endif
      end
    end else begin
      state_d = IDLE;
      bc_d    = '0;
      src_d   = 2'd0;
    end
  end

  // State and output registers; reset overrides everything sampled on the same edge.
  always_ff @(posedge ck) begin
    if (reset) begin
      state_q <= IDLE;
      bc_q    <= '0;
      q_q     <= '0;
      qv_q    <= 1'b0;
      src_q   <= 2'd0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef SHARED_PORT_STATS_EN
      cnt1_q  <= '0;
      cnt2_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      bc_q    <= bc_d;
      q_q     <= q_d;
      qv_q    <= qv_d;
      src_q   <= src_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
`ifdef SHARED_PORT_STATS_EN
      cnt1_q  <= cnt1_d;
      cnt2_q  <= cnt2_d;
`endif
    end
  end

  assign bus.q   = q_q;
  assign bus.qv  = qv_q;
  assign bus.src = src_q;
  assign bus.ovf = ovf_q;
  assign bus.err = err_q;
`ifdef SHARED_PORT_STATS_EN
  assign bus.cnt1 = cnt1_q;
  assign bus.cnt2 = cnt2_q;
`endif

endmodule

// File: tb/tb_shared_port.sv
// Self-checking bench for shared_port: directed scenarios plus randomized grants against a reference model.
// Latency: outputs sampled on the falling edge after each rising edge.
// Backpressure: none. Build macro: SHARED_PORT_STATS_EN enables the counter scenario (CW=2).
module tb_shared_port;
  localparam int W    = 8;
  localparam int MAXB = 4;
`ifdef SHARED_PORT_STATS_EN
  localparam int CW   = 2;
`endif

  logic ck;
  logic reset;
  int   total;
  int   bad;

  // Reference model: source of the current run and how long it has lasted.
  int           m_src;
  int           m_run;
  logic         m_err;
  logic [W-1:0] m_q;
  logic         m_qv;
  logic         m_ovf;
  int           m_cnt1;
  int           m_cnt2;

  shared_port_if #(.W(W)
`ifdef SHARED_PORT_STATS_EN
    , .CW(CW)
`endif
  ) bus ();

  shared_port #(.W(W), .MAXB(MAXB)
`ifdef SHARED_PORT_STATS_EN
    , .CW(CW)
`endif
  ) dut (
    .ck    (ck),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  // Drive one cycle of inputs, advance the model on the rising edge, return at the falling edge.
  task automatic step(input logic rs, input logic a1, input logic a2, input logic b1, input logic b2,
                      input logic [W-1:0] x1, input logic [W-1:0] x2);
    int s;
    reset  = rs;
    bus.g1 = a1;
    bus.g2 = a2;
    bus.v1 = b1;
    bus.v2 = b2;
    bus.d1 = x1;
    bus.d2 = x2;
    @(posedge ck);
    if (rs) begin
      m_src = 0; m_run = 0; m_err = 1'b0; m_q = '0; m_qv = 1'b0; m_ovf = 1'b0;
      m_cnt1 = 0; m_cnt2 = 0;
    end else if (m_err) begin
      m_qv = 1'b0;
    end else if (a1 && a2) begin
      m_err = 1'b1; m_qv = 1'b0; m_src = 0; m_run = 0; m_ovf = 1'b0;
    end else if (a1 || a2) begin
      s = a1 ? 1 : 2;
      m_run = (m_src == s) ? m_run + 1 : 1;
      m_src = s;
      m_ovf = (m_run > MAXB);
      m_qv  = 1'b0;
      if (s == 1 && b1) begin
        m_q = x1; m_qv = 1'b1; m_cnt1++;
      end
      if (s == 2 && b2) begin
        m_q = x2; m_qv = 1'b1; m_cnt2++;
      end
    end else begin
      m_src = 0; m_run = 0; m_qv = 1'b0; m_ovf = 1'b0;
    end
    @(negedge ck);
  endtask

  task automatic test_reset();
    // Reset coinciding with an illegal double grant must still win.
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hEE);
    total++; if (bus.q !== 8'h00) begin bad++; $display("FAIL reset_q got=%h exp=00", bus.q); end
    total++; if (bus.qv !== 1'b0) begin bad++; $display("FAIL reset_qv got=%b exp=0", bus.qv); end
    total++; if (bus.src !== 2'd0) begin bad++; $display("FAIL reset_src got=%0d exp=0", bus.src); end
    total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", bus.ovf); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus.err); end
`ifdef SHARED_PORT_STATS_EN
    total++; if (bus.cnt1 !== 2'd0 || bus.cnt2 !== 2'd0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", bus.cnt1, bus.cnt2); end
`endif
  endtask

  task automatic test_single_word();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h5A, 8'h00);
    total++; if (bus.q !== 8'h5A) begin bad++; $display("FAIL single_q got=%h exp=5a", bus.q); end
    total++; if (bus.qv !== 1'b1) begin bad++; $display("FAIL single_qv got=%b exp=1", bus.qv); end
    total++; if (bus.src !== 2'd1) begin bad++; $display("FAIL single_src got=%0d exp=1", bus.src); end
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h77, 8'h00);
    total++; if (bus.qv !== 1'b0) begin bad++; $display("FAIL single_qv_after got=%b exp=0", bus.qv); end
    total++; if (bus.src !== 2'd0) begin bad++; $display("FAIL single_src_after got=%0d exp=0", bus.src); end
    total++; if (bus.q !== 8'h5A) begin bad++; $display("FAIL single_q_hold got=%h exp=5a", bus.q); end
  endtask

  task automatic test_direct_switch();
    logic [1:0]   exp_src [4] = '{2'd1, 2'd1, 2'd2, 2'd2};
    logic [W-1:0] exp_q   [4] = '{8'h11, 8'h11, 8'h22, 8'h22};
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, (i < 2), (i >= 2), 1'b1, 1'b1, 8'h11, 8'h22);
      total++; if (bus.src !== exp_src[i]) begin bad++; $display("FAIL switch_src[%0d] got=%0d exp=%0d", i, bus.src, exp_src[i]); end
      total++; if (bus.q !== exp_q[i]) begin bad++; $display("FAIL switch_q[%0d] got=%h exp=%h", i, bus.q, exp_q[i]); end
      total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL switch_ovf[%0d] got=%b exp=0", i, bus.ovf); end
    end
  endtask

  task automatic test_overrun();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 1; i <= 7; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, W'(i));
      total++; if (bus.ovf !== (i > MAXB)) begin bad++; $display("FAIL overrun_ovf[%0d] got=%b exp=%b", i, bus.ovf, (i > MAXB)); end
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL overrun_drop got=%b exp=0", bus.ovf); end
  endtask

  task automatic test_protocol_error();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h31, 8'h00);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h32, 8'h42);
    total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL perr_err got=%b exp=1", bus.err); end
    total++; if (bus.qv !== 1'b0 || bus.src !== 2'd0) begin bad++; $display("FAIL perr_port got=%b/%0d exp=0/0", bus.qv, bus.src); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, (i != 1), (i == 1), 1'b1, 1'b1, 8'h33, 8'h43);
      total++; if (bus.err !== 1'b1 || bus.qv !== 1'b0) begin bad++; $display("FAIL perr_sticky[%0d] got=%b/%b exp=1/0", i, bus.err, bus.qv); end
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL perr_clear got=%b exp=0", bus.err); end
  endtask

  task automatic test_reset_mid_burst();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA1, 8'h00);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA2, 8'h00);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA3, 8'h00);
    total++; if ({bus.q, bus.qv, bus.src, bus.ovf, bus.err} !== '0) begin bad++; $display("FAIL midrst_zero got=%h/%b/%0d/%b/%b exp=all 0", bus.q, bus.qv, bus.src, bus.ovf, bus.err); end
    for (int i = 1; i <= MAXB + 1; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, W'(8'hB0 + i), 8'h00);
      total++; if (bus.src !== 2'd1 || bus.ovf !== (i > MAXB)) begin bad++; $display("FAIL midrst_burst[%0d] got=%0d/%b exp=1/%b", i, bus.src, bus.ovf, (i > MAXB)); end
    end
  endtask

`ifdef SHARED_PORT_STATS_EN
  task automatic test_stats();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, W'(i), 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h10, 8'h20);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 8'h21);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h12, 8'h22);
    total++; if (bus.cnt1 !== 2'd1) begin bad++; $display("FAIL stats_cnt1 got=%0d exp=1", bus.cnt1); end
    total++; if (bus.cnt2 !== 2'd1) begin bad++; $display("FAIL stats_cnt2 got=%0d exp=1", bus.cnt2); end
  endtask
`endif

  task automatic test_random();
    logic a1, a2, rs;
    a1 = 1'b0; a2 = 1'b0;
    for (int i = 0; i < 600; i++) begin
      rs = ($urandom_range(0, 99) < (m_err ? 20 : 2));
      if ($urandom_range(0, 99) < 25) begin
        case ($urandom_range(0, 19))
          0:               begin a1 = 1'b1; a2 = 1'b1; end
          1, 2, 3, 4:      begin a1 = 1'b0; a2 = 1'b0; end
          5, 6, 7, 8, 9, 10, 11: begin a1 = 1'b1; a2 = 1'b0; end
          default:         begin a1 = 1'b0; a2 = 1'b1; end
        endcase
      end
      step(rs, a1, a2, 1'($urandom), 1'($urandom), W'($urandom), W'($urandom));
      total++; if (bus.qv !== m_qv) begin bad++; $display("FAIL rand_qv[%0d] got=%b exp=%b", i, bus.qv, m_qv); end
      total++; if (bus.q !== m_q) begin bad++; $display("FAIL rand_q[%0d] got=%h exp=%h", i, bus.q, m_q); end
      total++; if (bus.src !== 2'(m_src)) begin bad++; $display("FAIL rand_src[%0d] got=%0d exp=%0d", i, bus.src, m_src); end
      total++; if (bus.ovf !== m_ovf) begin bad++; $display("FAIL rand_ovf[%0d] got=%b exp=%b", i, bus.ovf, m_ovf); end
      total++; if (bus.err !== m_err) begin bad++; $display("FAIL rand_err[%0d] got=%b exp=%b", i, bus.err, m_err); end
`ifdef SHARED_PORT_STATS_EN
      total++; if (bus.cnt1 !== CW'(m_cnt1) || bus.cnt2 !== CW'(m_cnt2)) begin bad++; $display("FAIL rand_cnt[%0d] got=%0d/%0d exp=%0d/%0d", i, bus.cnt1, bus.cnt2, CW'(m_cnt1), CW'(m_cnt2)); end
`endif
    end
  endtask

  initial begin
    total = 0; bad = 0;
    m_src = 0; m_run = 0; m_err = 1'b0; m_q = '0; m_qv = 1'b0; m_ovf = 1'b0;
    m_cnt1 = 0; m_cnt2 = 0;
    reset = 1'b1;
    bus.g1 = 1'b0; bus.g2 = 1'b0; bus.v1 = 1'b0; bus.v2 = 1'b0;
    bus.d1 = '0; bus.d2 = '0;
    @(negedge ck);
    test_reset();
    test_single_word();
    test_direct_switch();
    test_overrun();
    test_protocol_error();
    test_reset_mid_burst();
`ifdef SHARED_PORT_STATS_EN
    test_stats();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/shared_port.md
# shared_port

Downstream stage of the two-requester arbiter. It consumes the arbiter grants `g1`/`g2` and the two devices' data words, forwards the granted device's word onto one registered shared output port, and tags each word with its source. It also polices the grants: it flags simultaneous grants as a protocol error and flags grants held longer than a burst limit.

## Interface
- `W`, 8, data word width.
- `MAXB`, 4, maximum consecutive grant cycles per burst before overrun is flagged (≥1).
- `CW`, 8, width of per-device word counters (only with the config macro).

- `ck`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset, sampled on the `ck` rising edge.
- `g1`, `g2`  in  1 each  grants from the arbiter.
- `v1`, `v2`  in  1 each  word-valid from device 1 / device 2.
- `d1`, `d2`  in  W each  data from device 1 / device 2.
- `q`  out  W  shared port data.
- `qv`  out  1  `q` valid.
- `src`  out  2  source of the current burst: 0 none, 1 device 1, 2 device 2 (3 never driven).
- `ovf`  out  1  burst overrun.
- `err`  out  1  sticky grant-protocol error.
- `cnt1`, `cnt2`  out  CW each  accepted-word counters (macro only).

## Operation
- States: IDLE, SERVE1, SERVE2, ERR. A burst counter `bc` saturates at MAXB+1.
- Edge with `reset`=1: state IDLE, `bc`=0, `q`=0, `qv`=0, `src`=0, `ovf`=0, `err`=0, `cnt1`=`cnt2`=0. This holds regardless of current state, including ERR and mid-burst.
- Any state except ERR, sampled `g1`&`g2`=1: go to ERR, `err`=1, `qv`=0, `src`=0, `ovf`=0. ERR is left only by reset.
- Any state except ERR, sampled `g1`&!`g2`:
  - go to SERVE1.
  - `bc`=1 if the previous state was not SERVE1, else `bc`=min(`bc`+1, MAXB+1).
  - `src`=1.
- `g2`&!`g1` behaves symmetrically (SERVE2, `src`=2).
- Neither grant sampled: go to IDLE, `bc`=0, `src`=0.
- SERVE1→SERVE2 (and the reverse) with no IDLE cycle is legal and restarts `bc` at 1.
- Word acceptance: on an edge entering or staying in SERVEx with `vx`=1, the block sets `q`=`dx` and `qv`=1. Otherwise `qv`=0 and `q` holds its last value.
- Valid from the non-granted device is ignored.
- `ovf` = 1 while the registered state is SERVEx and `bc` > MAXB. It clears on the edge the burst ends or the source switches.

## Timing
- Inputs are sampled at edge k. `q`, `qv`, `src`, `ovf` and `err` update at edge k and are visible during cycle k..k+1. Latency is one cycle; there are no combinational input-to-output paths.
- `ovf` first asserts after edge MAXB+1 of a continuous grant, i.e. the (MAXB+1)th consecutive granted sample.
- Reset has priority over every other event sampled on the same edge, including a simultaneous-grant error.

## Configuration
- `SHARED_PORT_STATS_EN` defined: `cnt1`/`cnt2` are present.
  - Each counter increments on every accepted word from its device.
  - Counters wrap modulo 2^CW.
  - Counters are cleared only by reset and frozen in ERR.
- Macro undefined: ports `cnt1`/`cnt2` and the counter logic are absent. All other behaviour is identical.

## Test plan
- **Single word:** reset, then `g1`=`v1`=1, `d1`=0x5A for one cycle → one cycle later `q`=0x5A, `qv`=1, `src`=1. Next cycle `qv`=0, `src`=0.
- **Direct switch:** `g1` held 2 cycles, then `g2` 2 cycles, with `v1`=`v2`=1 and `d1`=0x11, `d2`=0x22 →
  - `src` sequence 1,1,2,2 with no IDLE gap.
  - `q` sequence 0x11,0x11,0x22,0x22.
  - `ovf`=0 throughout.
- **Overrun:** MAXB=4, `g2` held 7 cycles → `ovf`=1 in output cycles 5–7. `ovf`=0 the cycle after `g2` drops.
- **Protocol error:** `g1`=`g2`=1 for one cycle during SERVE1 → `err`=1 next cycle and stays 1 after grants return to legal values. `qv` stays 0 until `reset`. After reset `err`=0.
- **Reset mid-burst:** `reset`=1 on the third cycle of a `g1` burst → next cycle all outputs 0 and state IDLE. With `g1` still held, `src`=1 and `bc` restarts at 1.
- **Stats (`SHARED_PORT_STATS_EN`, CW=2):** 5 accepted words from device 1 and 1 from device 2 → `cnt1`=1 (wrapped), `cnt2`=1. Words offered while the device is not granted do not count.
